// File: rtl/vga_sync_controller.sv
// vga_sync_controller
// Owns raster timing for the VGA path: divides clk down to a pixel tick,
// steps the horizontal/vertical counters, emits the end-of-line and
// start-of-frame strobes and decodes hsync/vsync/video_on (registered,
// one clk behind the counters).
//
// Build option: define VGA_FRAME_CNT_EN to add an 8-bit frame_count output
// that advances on every frame_start. Without it the port does not exist.
//
// Reset is asynchronous and active-high.

module vga_sync_controller #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  output logic [9:0] h_count,
  output logic [9:0] v_count,
  output logic       enable_v,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  // Reject geometries the 4-bit divider or 10-bit counters cannot hold.
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_sync_controller: CLK_DIV must be 1..16");
  end
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_sync_controller: H_TOTAL and V_TOTAL must fit in 10 bits");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_sync_controller: sync widths must be at least 1");
  end

  logic [3:0] div_q, div_d;
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;
  logic       tick;
  logic       line_end;
  logic       frame_end;

  // Strobes are combinational from registered state so they line up with
  // the edge that actually wraps the counters; run low kills them at once.
  assign tick      = run && (div_q == DIV_LAST);
  assign line_end  = tick && (h_q == H_LAST);
  assign frame_end = line_end && (v_q == V_LAST);

  // Pixel divider: free-runs 0..CLK_DIV-1 while run is high, holds otherwise.
  always_comb begin
    div_d = div_q;
    if (run) begin
      div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    end
  end

  // Horizontal position advances once per pixel tick and wraps at the line end.
  always_comb begin
    h_d = h_q;
    if (tick) begin
      h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    end
  end

  // Vertical line advances on each line end and wraps at the frame end.
  always_comb begin
    v_d = v_q;
    if (line_end) begin
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Decode syncs and visible area from the current counters; registered below.
  always_comb begin
    hsync_d = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_d = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
    video_d = run && (h_q < H_VIS) && (v_q < V_VIS);
  end

  // Raster state and decoded outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= 4'd0;
      h_q     <= 10'd0;
      v_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      video_q <= video_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Frame counter wraps naturally at 255; frame_end already implies run.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
`endif

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign enable_v    = line_end;
  assign frame_start = frame_end;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_q;

endmodule
